// File: rtl/fetch_unit.sv
// Instruction fetch unit: a four-state sequencer that fetches one word, holds it
// for the decoder until execution completes, then redirects the PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  // imem handshake: imem_req is the valid side, held with a stable imem_addr;
  // imem_ready is the ready side, and a word transfers on any edge where both are 1.
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  input  logic        exec_done,
  input  logic        jump,
  input  logic        jr,
  input  logic        beq,
  input  logic        bne,
  input  logic        blez,
  input  logic        bgtz,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        fault,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        load_instr;
  logic        retire;

  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        rs_neg;
  logic        rs_zero;
  logic        taken;
  logic [31:0] next_pc;
  logic        misaligned;

  assign state_dbg = state;
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign op        = instr[31:26];
  assign funct     = instr[5:0];

  // Redirect target selection; jr wins over jump, which wins over any branch.
  always_comb begin
    branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    branch_target = pc_plus4 + branch_off;
    jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    rs_neg        = rs_data[31];
    rs_zero       = (rs_data == 32'd0);
    taken         = (beq  & alu_zero)
                  | (bne  & ~alu_zero)
                  | (blez & (rs_neg | rs_zero))
                  | (bgtz & ~rs_neg & ~rs_zero);
    if (jr)         next_pc = rs_data;
    else if (jump)  next_pc = jump_target;
    else if (taken) next_pc = branch_target;
    else            next_pc = pc_plus4;
    misaligned    = (next_pc[1:0] != 2'b00);
  end

  always_comb begin
    state_next  = state;
    load_instr  = 1'b0;
    retire      = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    case (state)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_instr = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          retire     = 1'b1;
          state_next = misaligned ? FAULT : FETCH;
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // A misaligned redirect still counts as retired, but the PC keeps pointing at
  // the instruction that produced it so software can locate the fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      instr   <= 32'd0;
      retired <= 32'd0;
    end else begin
      state <= state_next;
      if (load_instr) begin
        instr <= imem_rdata;
      end
      if (retire) begin
        retired <= retired + 32'd1;
        if (!misaligned) begin
          pc <= next_pc;
        end
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-005 imem_addr  output  32  SHALL be the fetch address, equal to pc.
REQ-006 imem_ready  input  1  SHALL mean imem_rdata is valid this cycle.
REQ-007 imem_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-008 instr  output  32  SHALL be the registered current instruction.
REQ-009 instr_valid  output  1  SHALL mean instr, op and funct are valid for the decoder.
REQ-010 op  output  6  SHALL be instr[31:26], feeding the decoder op_i.
REQ-011 funct  output  6  SHALL be instr[5:0], feeding the decoder funct_i.
REQ-012 exec_done  input  1  SHALL mean the current instruction has completed and the redirect inputs are valid.
REQ-013 jump, jr, beq, bne, blez, bgtz  input  1 each  SHALL be the decoder control outputs.
REQ-014 alu_zero  input  1  SHALL be the ALU zero flag (rs-rt).
REQ-015 rs_data  input  32  SHALL be the register-file rs read value.
REQ-016 pc  output  32  SHALL be the address of the current instruction.
REQ-017 pc_plus4  output  32  SHALL equal pc+4 (mod 2^32), used as the link value.
REQ-018 retired  output  32  SHALL count completed instructions.
REQ-019 fault  output  1  SHALL flag a misaligned next PC.

Function
REQ-020 The FSM SHALL have exactly four states: BOOT, FETCH, HOLD and FAULT.
REQ-021 BOOT SHALL drive imem_req=0 and SHALL move unconditionally to FETCH on the next edge.
REQ-022 FETCH SHALL drive imem_req=1 with imem_addr=pc held stable until acceptance.
REQ-023 In FETCH, on an edge where imem_ready=1: instr<=imem_rdata, state<=HOLD, so instr_valid=1 in the next cycle (minimum fetch latency 1 cycle).
REQ-024 In FETCH with imem_ready=0, all state SHALL be held, with no limit on wait states.
REQ-025 HOLD SHALL drive instr_valid=1 and imem_req=0; instr SHALL remain constant.
REQ-026 exec_done SHALL be ignored in BOOT, FETCH and FAULT.
REQ-027 In HOLD, on an edge with exec_done=1: pc<=next_pc, retired<=retired+1 (wrapping 0xFFFF_FFFF to 0), and state<=FETCH, or state<=FAULT per REQ-031.
REQ-028 Branch target SHALL be pc_plus4 + ({{14{instr[15]}},instr[15:0],2'b00}), computed mod 2^32; jump target SHALL be {pc_plus4[31:28],instr[25:0],2'b00}.
REQ-029 Branch taken SHALL be (beq&alu_zero) | (bne&~alu_zero) | (blez & signed rs_data<=0) | (bgtz & signed rs_data>0).
REQ-030 next_pc priority SHALL be jr -> rs_data, else jump -> jump target, else taken -> branch target, else pc_plus4, with no delay slot and the priority applying to any illegal combination of inputs.
REQ-031 If next_pc[1:0]!=0: state<=FAULT, pc SHALL keep the faulting instruction's address, and retired SHALL still increment.
REQ-032 FAULT SHALL drive fault=1, imem_req=0 and instr_valid=0, and SHALL be left only by reset.
REQ-033 instr_valid SHALL be 1 only in HOLD, and imem_req SHALL be 1 only in FETCH; the two SHALL never be 1 in the same cycle.

Reset
REQ-034 An edge with rst=1 SHALL set state=BOOT, pc=RESET_PC, instr=0, retired=0 and fault=0, regardless of state, including mid-fetch and mid-HOLD.
REQ-035 A memory response (imem_ready=1) on a reset edge SHALL be discarded.
REQ-036 While in BOOT after reset, outputs SHALL be imem_req=0, instr_valid=0, op=0, funct=0, pc=0x0000_3000 and pc_plus4=0x0000_3004.

Verification
REQ-037 Reset then imem_ready=1 with rdata=0x0000_0020, then exec_done=1 with no control inputs -> instr_valid high 1 cycle after acceptance, funct=0x20, pc=0x3004, retired=1.
REQ-038 imem_ready held 0 for 5 cycles in FETCH -> imem_req=1 and imem_addr=0x3000 stable throughout, instr_valid=0.
REQ-039 beq=1, alu_zero=1, instr=0x1000_FFFF at pc=0x3010 -> next pc=0x3010; with alu_zero=0 -> next pc=0x3014.
REQ-040 jr=1 with jump=1, rs_data=0x0000_4000 -> pc=0x4000; jr=1 with rs_data=0x0000_4002 -> fault=1, pc unchanged, imem_req stays 0.
REQ-041 blez=1 with rs_data=0x8000_0000 -> taken; bgtz=1 with rs_data=0 -> not taken.
REQ-042 rst pulsed in HOLD with exec_done=1 -> pc=0x3000, retired=0, state BOOT, then FETCH one cycle later.
